// File: rtl/uart_fx_alu_pkg.sv
// Shared opcodes, frame-controller states and status-byte bit positions for uart_fx_alu_core.
package uart_fx_alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_MUL = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_A,
        ST_RX_B,
        ST_EXEC,
        ST_TX_SEND,
        ST_TX_WAIT
    } state_t;

    localparam int unsigned STAT_OVF_BIT = 0;
    localparam int unsigned STAT_INV_BIT = 1;

endpackage

// File: rtl/uart_fx_alu_core_alu.sv
// fx_alu: two-stage signed saturating fixed-point datapath (raw result, then shift + saturate).
module fx_alu
    import uart_fx_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              En_in,
    input  logic [7:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic              ovf,
    output logic              inv,
    output logic              c_valid_out
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [PW-1:0] a_x, b_x;
    logic signed [PW-1:0] raw_d, raw_q;
    logic                 mul_d, mul_q;
    logic                 inv1_d, inv1_q;
    logic                 v1_q;

    logic signed [PW-1:0] shifted, sat;
    logic [DATA_W-1:0]    c_d, c_q;
    logic                 ovf_d, ovf_q;
    logic                 inv2_q;
    logic                 v2_q;

    // Sign-extended operands make every op, logic included, a sign-extended PW-bit value.
    assign a_x = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_x = {{DATA_W{b[DATA_W-1]}}, b};

    always_comb begin
        raw_d  = '0;
        mul_d  = 1'b0;
        inv1_d = 1'b0;
        case (opcode)
            OP_ADD: raw_d = a_x + b_x;
            OP_SUB: raw_d = a_x - b_x;
            OP_MUL: begin
                raw_d = a_x * b_x;
                mul_d = 1'b1;
            end
            OP_AND: raw_d = a_x & b_x;
            OP_OR:  raw_d = a_x | b_x;
            OP_XOR: raw_d = a_x ^ b_x;
            default: inv1_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            raw_q  <= '0;
            mul_q  <= 1'b0;
            inv1_q <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= En_in;
            if (En_in) begin
                raw_q  <= raw_d;
                mul_q  <= mul_d;
                inv1_q <= inv1_d;
            end
        end
    end

    always_comb begin
        shifted = mul_q ? (raw_q >>> FRAC_W) : raw_q;
        sat     = shifted;
        ovf_d   = 1'b0;
        if (shifted > SAT_MAX) begin
            sat   = SAT_MAX;
            ovf_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat   = SAT_MIN;
            ovf_d = 1'b1;
        end
        c_d = DATA_W'(sat);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c_q    <= '0;
            ovf_q  <= 1'b0;
            inv2_q <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                c_q    <= c_d;
                ovf_q  <= ovf_d;
                inv2_q <= inv1_q;
            end
        end
    end

    assign c           = c_q;
    assign ovf         = ovf_q;
    assign inv         = inv2_q;
    assign c_valid_out = v2_q;

endmodule

// File: rtl/uart_fx_alu_core.sv
// Byte-serial frame controller around fx_alu: opcode, A, B in (MSB first), result out over TX.
// Optional UART_FX_ALU_CORE_STATUS_BYTE_EN appends a status byte {6'b0, inv, ovf} after the result.
module uart_fx_alu_core
    import uart_fx_alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FRAC_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        Rx_Byte_in,
    input  logic              Rx_DV_in,
    input  logic              Tx_Done_in,
    output logic              Tx_DV_out,
    output logic [7:0]        Tx_Byte_out,
    output logic              Busy_out,
    output logic [DATA_W-1:0] c_out
);

    localparam int unsigned NB    = DATA_W / 8;
`ifdef UART_FX_ALU_CORE_STATUS_BYTE_EN
    localparam int unsigned NTX   = NB + 1;
`else
    localparam int unsigned NTX   = NB;
`endif
    localparam int unsigned IDX_W = $clog2(NB + 2);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                alu_en_q, alu_en_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [DATA_W-1:0]   c_q, c_d;
    logic                ovf_q, ovf_d, inv_q, inv_d;
    logic [IDX_W-1:0]    tx_idx_q, tx_idx_d;
    logic                tx_dv_q, tx_dv_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [7:0]          tx_sel;

    logic [DATA_W-1:0]   alu_c;
    logic                alu_ovf, alu_inv, alu_valid;

    fx_alu #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
    ) u_alu (
        .CLK        (CLK),
        .RST        (RST),
        .En_in      (alu_en_q),
        .opcode     (op_q),
        .a          (a_q),
        .b          (b_q),
        .c          (alu_c),
        .ovf        (alu_ovf),
        .inv        (alu_inv),
        .c_valid_out(alu_valid)
    );

`ifdef UART_FX_ALU_CORE_STATUS_BYTE_EN
    // Index 0 is the trailing status byte; result bytes sit one index higher.
    always_comb begin
        tx_sel = '0;
        if (tx_idx_q == '0) begin
            tx_sel[STAT_OVF_BIT] = ovf_q;
            tx_sel[STAT_INV_BIT] = inv_q;
        end else begin
            tx_sel = 8'(c_q >> {tx_idx_q - 1'b1, 3'b000});
        end
    end
`else
    logic [1:0] flags_unused;
    assign flags_unused = {ovf_q, inv_q};

    always_comb begin
        tx_sel = 8'(c_q >> {tx_idx_q, 3'b000});
    end
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_en_d  = 1'b0;
        cnt_d     = cnt_q;
        to_d      = to_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        inv_d     = inv_q;
        tx_idx_d  = tx_idx_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;

        case (state_q)
            ST_IDLE: begin
                if (Rx_DV_in) begin
                    op_d    = Rx_Byte_in;
                    cnt_d   = '0;
                    to_d    = '0;
                    state_d = ST_RX_A;
                end
            end
            ST_RX_A, ST_RX_B: begin
                if (Rx_DV_in) begin
                    to_d = '0;
                    if (state_q == ST_RX_A) a_sh_d = (a_sh_q << 8) | DATA_W'(Rx_Byte_in);
                    else                    b_sh_d = (b_sh_q << 8) | DATA_W'(Rx_Byte_in);
                    if (cnt_q == IDX_W'(NB - 1)) begin
                        cnt_d = '0;
                        if (state_q == ST_RX_A) begin
                            state_d = ST_RX_B;
                        end else begin
                            // Operands are committed only once the whole frame has arrived.
                            a_d      = a_sh_q;
                            b_d      = b_sh_d;
                            alu_en_d = 1'b1;
                            state_d  = ST_EXEC;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_EXEC: begin
                if (alu_valid) begin
                    c_d      = alu_c;
                    ovf_d    = alu_ovf;
                    inv_d    = alu_inv;
                    tx_idx_d = IDX_W'(NTX - 1);
                    state_d  = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = tx_sel;
                state_d   = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (Tx_Done_in) begin
                    if (tx_idx_q != '0) begin
                        tx_idx_d = tx_idx_q - 1'b1;
                        state_d  = ST_TX_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_en_q  <= 1'b0;
            cnt_q     <= '0;
            to_q      <= '0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
            tx_idx_q  <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_en_q  <= alu_en_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            c_q       <= c_d;
            ovf_q     <= ovf_d;
            inv_q     <= inv_d;
            tx_idx_q  <= tx_idx_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign Tx_DV_out   = tx_dv_q;
    assign Tx_Byte_out = tx_byte_q;
    assign Busy_out    = (state_q != ST_IDLE);
    assign c_out       = c_q;

endmodule

// File: tb/tb_uart_fx_alu_core.sv
// Scoreboard bench for uart_fx_alu_core (DATA_W=16, FRAC_W=3, TIMEOUT_CYC=50).
module tb_uart_fx_alu_core;

    localparam int DW  = 16;
    localparam int FW  = 3;
    localparam int TO  = 50;
`ifdef UART_FX_ALU_CORE_STATUS_BYTE_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif
    localparam int NTX = DW / 8 + STAT;

    logic          CLK = 1'b0;
    logic          RST;
    logic [7:0]    Rx_Byte_in;
    logic          Rx_DV_in;
    logic          Tx_Done_in;
    logic          Tx_DV_out;
    logic [7:0]    Tx_Byte_out;
    logic          Busy_out;
    logic [DW-1:0] c_out;

    uart_fx_alu_core #(
        .DATA_W     (DW),
        .FRAC_W     (FW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Rx_Byte_in (Rx_Byte_in),
        .Rx_DV_in   (Rx_DV_in),
        .Tx_Done_in (Tx_Done_in),
        .Tx_DV_out  (Tx_DV_out),
        .Tx_Byte_out(Tx_Byte_out),
        .Busy_out   (Busy_out),
        .c_out      (c_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]    b;
        bit            chk_c;
        logic [DW-1:0] c;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned tx_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic with floor division for the fixed-point rescale.
    function automatic void model(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] r, output bit ovf, output bit inv);
        longint sa, sb, v, p, scale, hi, lo;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        scale = longint'(1) << FW;
        hi    = (longint'(1) << (DW - 1)) - 1;
        lo    = -(longint'(1) << (DW - 1));
        ovf   = 0;
        inv   = 0;
        v     = 0;
        r     = '0;
        case (op)
            8'h00, 8'h01, 8'h02: begin
                if (op == 8'h00)      v = sa + sb;
                else if (op == 8'h01) v = sa - sb;
                else begin
                    p = sa * sb;
                    v = p / scale;
                    if (p < 0 && (p % scale) != 0) v = v - 1;
                end
                if (v > hi) begin v = hi; ovf = 1; end
                if (v < lo) begin v = lo; ovf = 1; end
                r = DW'(v);
            end
            8'h03: r = a & b;
            8'h04: r = a | b;
            8'h05: r = a ^ b;
            default: inv = 1;
        endcase
    endfunction

    task automatic push_expect(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        bit            ovf, inv;
        exp_t          e;
        model(op, a, b, r, ovf, inv);
        for (int i = DW / 8 - 1; i >= 0; i--) begin
            e.b     = 8'(r >> (8 * i));
            e.chk_c = (i == DW / 8 - 1);
            e.c     = r;
            exp_q.push_back(e);
        end
        if (STAT != 0) begin
            e.b     = {6'b0, inv, ovf};
            e.chk_c = 0;
            e.c     = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        Rx_Byte_in = b;
        Rx_DV_in   = 1'b1;
        @(posedge CLK);
        #1;
        Rx_DV_in   = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input int maxgap);
        rx_byte(op);
        for (int i = DW / 8 - 1; i >= 0; i--) begin
            idle($urandom_range(0, maxgap));
            rx_byte(8'(a >> (8 * i)));
        end
        for (int i = DW / 8 - 1; i >= 0; i--) begin
            idle($urandom_range(0, maxgap));
            rx_byte(8'(b >> (8 * i)));
        end
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (!Busy_out && exp_q.size() == 0) done = 1;
            else idle(1);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done: got busy/pending=%0d, expected frame completion", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        push_expect(op, a, b);
        rx_frame(op, a, b, 2);
        wait_done("frame");
    endtask

    // Monitor: every Tx_DV_out pulse pops one expected byte.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (Tx_DV_out === 1'b1) begin
                tx_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got byte 0x%0h, expected no transmission", Tx_Byte_out);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 64'(Tx_Byte_out), 64'(e.b));
                    if (e.chk_c) check("c_out", 64'(c_out), 64'(e.c));
                end
            end
        end
    end

    // TX UART stand-in: acknowledges each byte after a random delay.
    initial begin : responder
        Tx_Done_in = 1'b0;
        forever begin
            @(negedge CLK);
            if (Tx_DV_out === 1'b1 && RST !== 1'b1) begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                @(posedge CLK);
                #1 Tx_Done_in = 1'b1;
                @(posedge CLK);
                #1 Tx_Done_in = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int            lat;
        int unsigned   t0;
        logic [DW-1:0] c_before;
        logic [7:0]    op;
        logic [DW-1:0] a, b;

        RST        = 1'b1;
        Rx_Byte_in = '0;
        Rx_DV_in   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx_dv",   64'(Tx_DV_out),   64'd0);
        check("rst_tx_byte", 64'(Tx_Byte_out), 64'd0);
        check("rst_busy",    64'(Busy_out),    64'd0);
        check("rst_c_out",   64'(c_out),       64'd0);
        RST = 1'b0;
        idle(2);

        send_frame(8'h00, 16'h0010, 16'h0018);
        send_frame(8'h02, 16'h0010, 16'h0018);
        send_frame(8'h02, 16'hFFF0, 16'h0018);
        send_frame(8'h00, 16'h7FFF, 16'h0001);
        send_frame(8'h01, 16'h8000, 16'h0001);
        send_frame(8'hFF, 16'h1234, 16'h5678);
        send_frame(8'h02, 16'h7FFF, 16'h7FFF);
        send_frame(8'h02, 16'hFFFF, 16'h0001);
        send_frame(8'h03, 16'hF0F0, 16'h3C3C);

        // Fixed pipeline latency from the last operand byte to the first TX pulse.
        push_expect(8'h00, 16'h0100, 16'h0023);
        rx_frame(8'h00, 16'h0100, 16'h0023, 0);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge CLK);
            #1;
            if (i == 3) check("c_out_at_n3", 64'(c_out), 64'h0123);
            if (Tx_DV_out) lat = i;
        end
        check("first_tx_latency", 64'(lat), 64'd4);
        wait_done("latency");

        // Inter-byte timeout drops a partial frame.
        c_before = c_out;
        t0       = tx_cnt;
        rx_byte(8'h00);
        rx_byte(8'h12);
        idle(TO + 1);
        check("timeout_busy",  64'(Busy_out),    64'd0);
        check("timeout_no_tx", 64'(tx_cnt - t0), 64'd0);
        check("timeout_c_out", 64'(c_out),       64'(c_before));
        send_frame(8'h00, 16'h0100, 16'h0200);

        // A byte arriving in the cycle the timeout would fire is still accepted.
        push_expect(8'h00, 16'h1234, 16'h0101);
        rx_byte(8'h00);
        rx_byte(8'h12);
        idle(TO - 1);
        rx_byte(8'h34);
        rx_byte(8'h01);
        rx_byte(8'h01);
        wait_done("timeout_edge");

        // Reset while waiting on the first result byte.
        push_expect(8'h00, 16'h0010, 16'h0018);
        rx_frame(8'h00, 16'h0010, 16'h0018, 0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            if (Tx_DV_out) lat = i;
            else idle(1);
        end
        check("rst_test_tx_seen", 64'(lat != 0), 64'd1);
        RST = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_tx_dv",   64'(Tx_DV_out),   64'd0);
        check("midrst_tx_byte", 64'(Tx_Byte_out), 64'd0);
        check("midrst_busy",    64'(Busy_out),    64'd0);
        check("midrst_c_out",   64'(c_out),       64'd0);
        @(posedge CLK);
        #1;
        check("midrst_busy_next", 64'(Busy_out), 64'd0);
        RST = 1'b0;
        idle(8);
        send_frame(8'h01, 16'h0040, 16'h0008);

        t0 = tx_cnt;
        send_frame(8'h00, 16'h0010, 16'h0018);
        check("tx_pulse_count", 64'(tx_cnt - t0), 64'(NTX));

        for (int k = 0; k < 24; k++) begin
            op = 8'($urandom_range(0, 6));
            if (op == 8'h06) op = 8'($urandom_range(6, 255));
            a  = ($urandom_range(0, 3) == 0) ? 16'h8000 - 16'($urandom_range(0, 1)) : 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'h7FFF + 16'($urandom_range(0, 1)) : 16'($urandom);
            send_frame(op, a, b);
        end

        idle(5);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
